unsigned_mul_8x8_ha_reduce: RTL and testbench

UNSIGNED_MUL_8X8_HA_REDUCE -- requirements
Module: unsigned_mul_8x8_ha_reduce

---
 rtl/unsigned_mul_8x8_ha_reduce.sv | 110 +++++++++++
 tb/tb_unsigned_mul_8x8_ha_reduce.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_mul_8x8_ha_reduce.sv
// Final reduction stage of an 8x8 unsigned multiplier.
// Four half-adder compressed groups, each a 9-bit sum row (t) and a 7-bit carry row (b),
// are accumulated one group per cycle into a 17-bit exact sum. The 16-bit product is
// then either saturated or wrapped, depending on SAT_EN.
module unsigned_mul_8x8_ha_reduce #(
  parameter int unsigned SAT_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  ha_array_0_b,
  input  logic [6:0]  ha_array_1_b,
  input  logic [6:0]  ha_array_2_b,
  input  logic [6:0]  ha_array_3_b,
  input  logic [8:0]  ha_array_0_t,
  input  logic [8:0]  ha_array_1_t,
  input  logic [8:0]  ha_array_2_t,
  input  logic [8:0]  ha_array_3_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  gc;
  logic [16:0] acc;
  logic [8:0]  t_reg [4];
  logic [6:0]  b_reg [4];

  logic        take;
  logic [9:0]  group_val;
  logic [16:0] addend;
  logic [16:0] sum_next;
  logic [15:0] p_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;

  // Capture all four groups on a transfer so later input changes cannot reach the result
  always_ff @(posedge clk) begin
    if (take) begin
      t_reg[0] <= ha_array_0_t;
      t_reg[1] <= ha_array_1_t;
      t_reg[2] <= ha_array_2_t;
      t_reg[3] <= ha_array_3_t;
      b_reg[0] <= ha_array_0_b;
      b_reg[1] <= ha_array_1_b;
      b_reg[2] <= ha_array_2_b;
      b_reg[3] <= ha_array_3_b;
    end
  end

  // Weight the current group (carry row sits two places above the sum row), shift by 2*gc, and add
  always_comb begin
    group_val = {1'b0, t_reg[gc]} + {1'b0, b_reg[gc], 2'b00};
    addend    = {7'd0, group_val} << {gc, 1'b0};
    sum_next  = acc + addend;
    if ((SAT_EN != 0) && sum_next[16]) begin
      p_next = 16'hFFFF;
    end else begin
      p_next = sum_next[15:0];
    end
  end

  // Control: IDLE accepts, ACC adds one group per cycle, DONE holds the result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gc    <= 2'd0;
      acc   <= 17'd0;
      p     <= 16'd0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= ACC;
            gc    <= 2'd0;
            acc   <= 17'd0;
          end
        end
        ACC: begin
          acc <= sum_next;
          gc  <= gc + 2'd1;
          if (gc == 2'd3) begin
            state <= DONE;
            p     <= p_next;
            ovf   <= sum_next[16];
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reduce.sv
// Bench for unsigned_mul_8x8_ha_reduce: a saturating and a wrapping instance share stimulus.
// Expected sums come from a bit-weight model and travel through a scoreboard queue.
module tb_unsigned_mul_8x8_ha_reduce;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [8:0]  t_drv [4];
  logic [6:0]  b_drv [4];

  logic        in_ready_s, out_valid_s, ovf_s;
  logic        in_ready_w, out_valid_w, ovf_w;
  logic [15:0] p_s, p_w;

  int vectors;
  int miscompares;
  int sb [$];

  unsigned_mul_8x8_ha_reduce #(.SAT_EN(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .ha_array_0_b(b_drv[0]), .ha_array_1_b(b_drv[1]),
    .ha_array_2_b(b_drv[2]), .ha_array_3_b(b_drv[3]),
    .ha_array_0_t(t_drv[0]), .ha_array_1_t(t_drv[1]),
    .ha_array_2_t(t_drv[2]), .ha_array_3_t(t_drv[3]),
    .out_valid(out_valid_s), .out_ready(out_ready), .p(p_s), .ovf(ovf_s)
  );

  unsigned_mul_8x8_ha_reduce #(.SAT_EN(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .ha_array_0_b(b_drv[0]), .ha_array_1_b(b_drv[1]),
    .ha_array_2_b(b_drv[2]), .ha_array_3_b(b_drv[3]),
    .ha_array_0_t(t_drv[0]), .ha_array_1_t(t_drv[1]),
    .ha_array_2_t(t_drv[2]), .ha_array_3_t(t_drv[3]),
    .out_valid(out_valid_w), .out_ready(out_ready), .p(p_w), .ovf(ovf_w)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact sum from the bit weights: t_g[k] -> 2^(2g+k), b_g[k] -> 2^(2g+k+2)
  function automatic int modelSum(input logic [35:0] tv, input logic [27:0] bv);
    int s;
    s = 0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 9; k++) if (tv[9*g+k]) s += (1 << (2*g+k));
      for (int k = 0; k < 7; k++) if (bv[7*g+k]) s += (1 << (2*g+k+2));
    end
    return s;
  endfunction

  task automatic scramble();
    for (int g = 0; g < 4; g++) begin
      t_drv[g] = 9'($urandom);
      b_drv[g] = 7'($urandom);
    end
  endtask

  // Present one row set, complete the handshake and push the expected sum
  task automatic applyStimulus(input logic [35:0] tv, input logic [27:0] bv);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      t_drv[g] = tv[9*g +: 9];
      b_drv[g] = bv[7*g +: 7];
    end
    in_valid = 1'b1;
    compare("in_ready_before_handshake", 32'(in_ready_s), 32'd1);
    @(posedge clk);
    sb.push_back(modelSum(tv, bv));
    @(negedge clk);
    in_valid = 1'b1;
    scramble();
    @(negedge clk);
    compare("in_ready_in_acc", 32'(in_ready_s), 32'd0);
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency and value, apply optional backpressure, then release it
  task automatic checkOutput(input int hold);
    int lat;
    int s;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic        exp_ovf;
    lat = 1;
    while (lat < 20) begin
      if (out_valid_s === 1'b1) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    compare("latency", 32'(lat), 32'd4);
    compare("out_valid_wrap", 32'(out_valid_w), 32'd1);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard: observed=empty expected=entry");
      return;
    end
    s        = sb.pop_front();
    exp_ovf  = (s > 65535);
    exp_wrap = s[15:0];
    exp_sat  = exp_ovf ? 16'hFFFF : s[15:0];
    compare("p_sat", 32'(p_s), 32'(exp_sat));
    compare("ovf_sat", 32'(ovf_s), 32'(exp_ovf));
    compare("p_wrap", 32'(p_w), 32'(exp_wrap));
    compare("ovf_wrap", 32'(ovf_w), 32'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      scramble();
      @(posedge clk);
      @(negedge clk);
      compare("hold_out_valid", 32'(out_valid_s), 32'd1);
      compare("hold_in_ready", 32'(in_ready_s), 32'd0);
      compare("hold_p_sat", 32'(p_s), 32'(exp_sat));
      compare("hold_p_wrap", 32'(p_w), 32'(exp_wrap));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    compare("release_out_valid", 32'(out_valid_s), 32'd0);
    compare("release_in_ready", 32'(in_ready_s), 32'd1);
    compare("retain_p_sat", 32'(p_s), 32'(exp_sat));
    compare("retain_ovf_sat", 32'(ovf_s), 32'(exp_ovf));
  endtask

  initial begin
    int stray;
    logic [35:0] tv;
    logic [27:0] bv;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    for (int g = 0; g < 4; g++) begin
      t_drv[g] = 9'd0;
      b_drv[g] = 7'd0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare("reset_in_ready", 32'(in_ready_s), 32'd1);
    compare("reset_out_valid", 32'(out_valid_s), 32'd0);
    compare("reset_p", 32'(p_s), 32'd0);
    compare("reset_ovf", 32'(ovf_s), 32'd0);
    rst_n = 1'b1;

    // All zero with out_ready already high
    $display("[TB] zero operands");
    out_ready = 1'b1;
    applyStimulus(36'd0, 28'd0);
    checkOutput(0);

    // Single LSB of group 0 sum row
    $display("[TB] t0 = 1");
    applyStimulus({9'h0, 9'h0, 9'h0, 9'h001}, 28'd0);
    checkOutput(0);
    compare("t0_lsb_p", 32'(p_s), 32'h0001);

    // Carry row of group 1 plus sum row of group 2
    $display("[TB] b1 = 1, t2 = 0x10");
    applyStimulus({9'h0, 9'h010, 9'h0, 9'h0}, {7'h0, 7'h0, 7'h01, 7'h0});
    checkOutput(0);
    compare("mixed_p", 32'(p_s), 32'h0110);

    // Maximum input: saturate vs wrap
    $display("[TB] maximum operands");
    applyStimulus({4{9'h1FF}}, {4{7'h7F}});
    checkOutput(0);
    compare("max_p_sat", 32'(p_s), 32'hFFFF);
    compare("max_p_wrap", 32'(p_w), 32'h5257);
    compare("max_ovf_wrap", 32'(ovf_w), 32'd1);

    // Backpressure for three cycles with toggling inputs
    $display("[TB] backpressure");
    tv = {4{9'($urandom)}} | 36'h1;
    bv = {4{7'($urandom)}};
    applyStimulus(tv, bv);
    checkOutput(3);

    // Reset in the middle of accumulation (gc = 2)
    $display("[TB] reset during accumulation");
    applyStimulus({4{9'h0AB}}, {4{7'h15}});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    compare("midrst_out_valid", 32'(out_valid_s), 32'd0);
    compare("midrst_in_ready", 32'(in_ready_s), 32'd1);
    compare("midrst_p", 32'(p_s), 32'd0);
    compare("midrst_ovf", 32'(ovf_s), 32'd0);
    compare("midrst_p_wrap", 32'(p_w), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) stray++;
    end
    compare("no_stray_out_valid", 32'(stray), 32'd0);

    // Random transactions after the reset
    $display("[TB] random transactions");
    for (int n = 0; n < 4; n++) begin
      tv = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
      bv = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
      applyStimulus(tv, bv);
      checkOutput(n % 2);
    end

    compare("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
